// File: rtl/updown_pkg.sv
// Shared types and segment patterns for the up/down counter stream detector.
package updown_pkg;

    typedef enum logic [2:0] {
        EMPTY,
        ACQ_UP,
        ACQ_DOWN,
        LOCK_UP,
        LOCK_DOWN
    } state_t;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        HOLD,
        JUMP
    } step_t;

    // Segment patterns ordered {a,b,c,d,e,f,g}, active high
    localparam logic [6:0] SEG_U    = 7'b0111110;
    localparam logic [6:0] SEG_D    = 7'b0111101;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_E    = 7'b1001111;

endpackage

// File: rtl/updown_detector_seg_letter_enc.sv
// Combinational letter selection for the 7-segment display; "E" overrides the mode letter.
module seg_letter_enc
    import updown_pkg::*;
(
    input  logic   [0:0] err,
    input  state_t       state,
    output logic   [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (err[0]) begin
            seg = SEG_E;
        end else begin
            case (state)
                LOCK_UP:   seg = SEG_U;
                LOCK_DOWN: seg = SEG_D;
                default:   seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/updown_detector.sv
// Infers counting direction of an observed up/down counter stream and flags jumps.
// Optional: define UPDOWN_DET_STICKY_ERR_EN to hold err (and "E") until reset.
module updown_detector
    import updown_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    output logic             dir_up,
    output logic             dir_down,
    output logic             locked,
    output logic             err,
    output logic [3:0]       step_cnt,
    output logic             sega,
    output logic             segb,
    output logic             segc,
    output logic             segd,
    output logic             sege,
    output logic             segf,
    output logic             segg
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       step_q, step_d;
    logic             err_q, err_d;
    logic             dir_up_q, dir_down_q;
    logic [6:0]       seg_q, seg_d;
    step_t            cls;

    function automatic step_t classify(input logic [WIDTH-1:0] d);
        if (d == '0)
            return HOLD;
        else if (d == WIDTH'(1))
            return UP;
        else if (d == '1)
            return DOWN;
        else
            return JUMP;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    assign cls = classify(cnt_in - prev_q);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        step_d  = step_q;
`ifdef UPDOWN_DET_STICKY_ERR_EN
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif
        if (cnt_valid) begin
            prev_d = cnt_in;
            if (state_q == EMPTY) begin
                // First sample only establishes a reference; direction still unknown
                state_d = ACQ_UP;
                step_d  = 4'd0;
            end else begin
                case (cls)
                    UP: begin
                        if (state_q == ACQ_UP || state_q == LOCK_UP)
                            step_d = sat_inc(step_q);
                        else
                            step_d = 4'd1;
                        state_d = (step_d >= LOCK_CNT) ? LOCK_UP : ACQ_UP;
                    end
                    DOWN: begin
                        if (state_q == ACQ_DOWN || state_q == LOCK_DOWN)
                            step_d = sat_inc(step_q);
                        else
                            step_d = 4'd1;
                        state_d = (step_d >= LOCK_CNT) ? LOCK_DOWN : ACQ_DOWN;
                    end
                    JUMP: begin
                        state_d = ACQ_UP;
                        step_d  = 4'd0;
                        err_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    seg_letter_enc u_seg_enc (
        .err   (err_d),
        .state (state_d),
        .seg   (seg_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            prev_q     <= '0;
            step_q     <= 4'd0;
            err_q      <= 1'b0;
            dir_up_q   <= 1'b0;
            dir_down_q <= 1'b0;
            seg_q      <= SEG_DASH;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            err_q      <= err_d;
            dir_up_q   <= (state_d == LOCK_UP);
            dir_down_q <= (state_d == LOCK_DOWN);
            seg_q      <= seg_d;
        end
    end

    assign dir_up   = dir_up_q;
    assign dir_down = dir_down_q;
    assign locked   = dir_up_q | dir_down_q;
    assign err      = err_q;
    assign step_cnt = step_q;
    assign {sega, segb, segc, segd, sege, segf, segg} = seg_q;

endmodule

// File: tb/tb_updown_detector.sv
// Directed-vector bench for updown_detector with hand-computed expectations.
module tb_updown_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       cnt_valid = 1'b0;
    logic       dir_up, dir_down, locked, err;
    logic [3:0] step_cnt;
    logic       sega, segb, segc, segd, sege, segf, segg;
    logic [6:0] seg;

    int n_chk = 0;
    int n_bad = 0;

`ifdef UPDOWN_DET_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam logic [6:0] P_U    = 7'b0111110;
    localparam logic [6:0] P_D    = 7'b0111101;
    localparam logic [6:0] P_DASH = 7'b0000001;
    localparam logic [6:0] P_E    = 7'b1001111;

    updown_detector #(.WIDTH(4), .LOCK_N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .cnt_valid (cnt_valid),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .locked    (locked),
        .err       (err),
        .step_cnt  (step_cnt),
        .sega      (sega),
        .segb      (segb),
        .segc      (segc),
        .segd      (segd),
        .sege      (sege),
        .segf      (segf),
        .segg      (segg)
    );

    assign seg = {sega, segb, segc, segd, sege, segf, segg};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cnt_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input logic [3:0] v);
        cnt_in = v;
        cnt_valid = 1'b1;
        @(posedge clk);
        #1;
        cnt_valid = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic du, input logic dd,
                           input logic e, input logic [3:0] sc, input logic [6:0] sg);
        chk({tag, ".dir_up"},   dir_up,   du);
        chk({tag, ".dir_down"}, dir_down, dd);
        chk({tag, ".locked"},   locked,   du | dd);
        chk({tag, ".err"},      err,      e);
        chk({tag, ".step"},     step_cnt, sc);
        chk({tag, ".seg"},      seg,      sg);
    endtask

    initial begin
        #12;
        chk_all("reset", 0, 0, 0, 4'd0, P_DASH);
        rst = 1'b1;

        // Lock up on 1,2,3,4, then reverse via 5,4
        do_reset();
        send(4'h1); chk_all("up_s1", 0, 0, 0, 4'd0, P_DASH);
        send(4'h2); send(4'h3);
        chk_all("up_s3", 0, 0, 0, 4'd2, P_DASH);
        send(4'h4); chk_all("up_lock", 1, 0, 0, 4'd3, P_U);
        repeat (3) @(posedge clk);
        #1 chk_all("idle_hold", 1, 0, 0, 4'd3, P_U);
        send(4'h5); chk_all("up_s5", 1, 0, 0, 4'd4, P_U);
        send(4'h4); chk_all("reverse", 0, 0, 0, 4'd1, P_DASH);

        // Down lock across 0 -> F
        do_reset();
        send(4'h2); send(4'h1);
        chk_all("dn_s1", 0, 0, 0, 4'd1, P_DASH);
        send(4'h0); chk_all("dn_s0", 0, 0, 0, 4'd2, P_DASH);
        send(4'hF); chk_all("dn_lockF", 0, 1, 0, 4'd3, P_D);
        send(4'hE); chk_all("dn_sE", 0, 1, 0, 4'd4, P_D);

        // Holds are ignored
        do_reset();
        send(4'h2); send(4'h3);
        chk_all("hold_pre", 0, 0, 0, 4'd1, P_DASH);
        send(4'h3); send(4'h3); send(4'h3);
        chk_all("hold_mid", 0, 0, 0, 4'd1, P_DASH);
        send(4'h4); chk_all("hold_post", 0, 0, 0, 4'd2, P_DASH);

        // Jump 3 -> 7, then tracking resumes underneath
        do_reset();
        send(4'h2); send(4'h3);
        send(4'h7); chk_all("jump", 0, 0, 1, 4'd0, P_E);
        send(4'h7); chk_all("jump_after", 0, 0, STICKY, 4'd0, STICKY ? P_E : P_DASH);
        send(4'h8); send(4'h9); send(4'hA);
        chk_all("jump_relock", 1, 0, STICKY, 4'd3, STICKY ? P_E : P_U);

        // Saturation at 15 and F -> 0 counted as an up step
        do_reset();
        for (int i = 0; i < 16; i++) send(4'(i));
        chk_all("sat15", 1, 0, 0, 4'd15, P_U);
        send(4'h0); chk_all("sat_wrap", 1, 0, 0, 4'd15, P_U);

        // Asynchronous reset between edges while locked
        do_reset();
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        chk_all("pre_async", 1, 0, 0, 4'd3, P_U);
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 4'd0, P_DASH);
        rst = 1'b1;
        send(4'h9); chk_all("post_rst_s1", 0, 0, 0, 4'd0, P_DASH);
        send(4'hA); chk_all("post_rst_s2", 0, 0, 0, 4'd1, P_DASH);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
